// File: rtl/coupler_16_to_32_pkg.sv
// Shared definitions for the 16-to-32 tuple coupler.
// Provides the pairing state encoding, default word widths and the
// stream-terminator test used on the lowest tuple of an incoming word.
package coupler_16_to_32_pkg;

  // Default tuple width and the derived 16- and 32-tuple word widths.
  localparam int unsigned DATA_WIDTH_DEF = 128;
  localparam int unsigned W16            = 16 * DATA_WIDTH_DEF;
  localparam int unsigned W32            = 32 * DATA_WIDTH_DEF;

  // Widest tuple the terminator test accepts; narrower tuples are zero-extended.
  localparam int unsigned TUPLE_MAX_W    = 1024;

  // Pairing state: S_LO waits for the lower half, S_HI for the upper half.
  typedef enum logic {
    S_LO = 1'b0,
    S_HI = 1'b1
  } state_t;

  // A word is a stream terminator when its lowest tuple is all zero.
  function automatic logic is_terminator(input logic [TUPLE_MAX_W-1:0] tuple);
    return (tuple == '0);
  endfunction

endpackage

// File: rtl/coupler_16_to_32.sv
// Packs pairs of 16-tuple words from an upstream merger into 32-tuple words
// for the next, wider merger level. An all-zero lowest tuple marks the end
// of a stream; seen in the lower slot it is forwarded at once as a full zero
// word, so a tree level drains without waiting for a partner.
//
// Ports:
//   i_clk             clock, rising edge
//   i_rst             asynchronous active-high reset
//   i_fifo            upstream FWFT head word (valid while i_fifo_empty=0)
//   i_fifo_empty      upstream FIFO empty
//   o_fifo_read       pop upstream head this cycle (combinational)
//   i_fifo_out_ready  downstream can accept (registered before use)
//   o_out_fifo_write  o_data written downstream this cycle
//   o_data            packed 32-tuple word; low half is the earlier word
//   o_word_count      number of words written downstream (wraps)
module coupler_16_to_32
  import coupler_16_to_32_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned KEY_WIDTH  = 80
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [16*DATA_WIDTH-1:0] i_fifo,
  input  logic                     i_fifo_empty,
  output logic                     o_fifo_read,
  input  logic                     i_fifo_out_ready,
  output logic                     o_out_fifo_write,
  output logic [32*DATA_WIDTH-1:0] o_data,
  output logic [31:0]              o_word_count
);

  localparam int unsigned HALF_W = 16 * DATA_WIDTH;
  localparam int unsigned FULL_W = 32 * DATA_WIDTH;

  // Elaboration guard: key must fit in a tuple, tuple must fit the terminator test.
  if ((KEY_WIDTH > DATA_WIDTH) || (DATA_WIDTH > TUPLE_MAX_W)) begin : g_bad_params
    $error("coupler_16_to_32: unsupported DATA_WIDTH/KEY_WIDTH combination");
  end

  state_t              state_q;
  state_t              state_d;
  logic [HALF_W-1:0]   lo_reg;
  logic [FULL_W-1:0]   out_reg;
  logic                out_valid;
  logic                ready_q;

  logic                is_term_c;
  logic                slot_free_c;
  logic                lo_load_c;
  logic                out_load_c;
  logic                out_zero_c;

  // Terminator test depends only on the head word, never on read handshaking.
  assign is_term_c = is_terminator(TUPLE_MAX_W'(i_fifo[DATA_WIDTH-1:0]));

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_LO;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: only a read moves the pairing state.
  always_comb begin
    state_d = state_q;
    if (o_fifo_read) begin
      unique case (state_q)
        S_LO:    state_d = is_term_c ? S_LO : S_HI;
        S_HI:    state_d = S_LO;
        default: state_d = S_LO;
      endcase
    end
  end

  // Handshake and datapath load controls.
  always_comb begin
    o_out_fifo_write = 1'b0;
    slot_free_c      = 1'b0;
    o_fifo_read      = 1'b0;
    lo_load_c        = 1'b0;
    out_load_c       = 1'b0;
    out_zero_c       = 1'b0;

    o_out_fifo_write = ~i_rst & out_valid & ready_q;
    // The output slot frees up in the same cycle it drains, so a write and
    // a reload can share one edge without a bubble.
    slot_free_c      = ~out_valid | o_out_fifo_write;
    o_fifo_read      = ~i_rst & ~i_fifo_empty & slot_free_c;

    if (o_fifo_read) begin
      unique case (state_q)
        S_LO: begin
          lo_load_c  = ~is_term_c;
          out_load_c = is_term_c;
          out_zero_c = is_term_c;
        end
        S_HI: begin
          out_load_c = 1'b1;
        end
        default: begin
          lo_load_c  = 1'b0;
        end
      endcase
    end
  end

  // Lower-half holding register, output register/valid pair, ready pipe, counter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      lo_reg       <= '0;
      out_reg      <= '0;
      out_valid    <= 1'b0;
      ready_q      <= 1'b0;
      o_word_count <= '0;
    end else begin
      ready_q <= i_fifo_out_ready;

      if (lo_load_c) begin
        lo_reg <= i_fifo;
      end

      // A reload on the same edge as a write keeps the slot occupied.
      if (out_load_c) begin
        out_reg   <= out_zero_c ? '0 : {i_fifo, lo_reg};
        out_valid <= 1'b1;
      end else if (o_out_fifo_write) begin
        out_valid <= 1'b0;
      end

      if (o_out_fifo_write) begin
        o_word_count <= o_word_count + 32'd1;
      end
    end
  end

  assign o_data = out_reg;

endmodule

// File: tb/tb_coupler_16_to_32.sv
module tb_coupler_16_to_32;
  import coupler_16_to_32_pkg::*;

  localparam int unsigned DW = DATA_WIDTH_DEF;

  typedef logic [W16-1:0] w16_t;
  typedef logic [W32-1:0] w32_t;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  w16_t        i_fifo = '0;
  logic        i_fifo_empty = 1'b1;
  logic        o_fifo_read;
  logic        i_fifo_out_ready = 1'b1;
  logic        o_out_fifo_write;
  w32_t        o_data;
  logic [31:0] o_word_count;

  int checks = 0;
  int errors = 0;

  w16_t src_q[$];     // upstream FIFO contents
  w32_t exp_q[$];     // expected downstream words, in order
  int   exp_count = 0;
  bit   have_lo = 0;
  w16_t lo_word = '0;

  coupler_16_to_32 #(.DATA_WIDTH(DW), .KEY_WIDTH(80)) dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .i_fifo           (i_fifo),
    .i_fifo_empty     (i_fifo_empty),
    .o_fifo_read      (o_fifo_read),
    .i_fifo_out_ready (i_fifo_out_ready),
    .o_out_fifo_write (o_out_fifo_write),
    .o_data           (o_data),
    .o_word_count     (o_word_count)
  );

  always #5 i_clk = ~i_clk;

  // Reference: the output stream is the input stream cut into pairs, where a
  // terminator arriving with no partner stands alone as a zero word.
  task automatic model_push(input w16_t w);
    if (have_lo) begin
      exp_q.push_back({w, lo_word});
      have_lo = 0;
    end else if (w[DW-1:0] == '0) begin
      exp_q.push_back('0);
    end else begin
      lo_word = w;
      have_lo = 1;
    end
  endtask

  task automatic refresh();
    i_fifo_empty = (src_q.size() == 0);
    i_fifo       = (src_q.size() != 0) ? src_q[0] : '0;
  endtask

  task automatic push(input w16_t w);
    src_q.push_back(w);
    model_push(w);
    refresh();
  endtask

  function automatic w16_t rand_word(input bit term);
    w16_t w;
    for (int i = 0; i < int'(W16 / 32); i++) w[i*32 +: 32] = $urandom;
    if (term) w[DW-1:0] = '0;
    else if (w[DW-1:0] == '0) w[0] = 1'b1;
    return w;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  // Upstream FWFT FIFO: pop on the edge where the DUT reads.
  always @(posedge i_clk) begin
    if (o_fifo_read === 1'b1 && src_q.size() > 0) void'(src_q.pop_front());
    #1 refresh();
  end

  // Monitor: every downstream write is matched against the scoreboard.
  always @(negedge i_clk) begin
    if (o_out_fifo_write === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: actual hi %h lo %h required no write",
                 o_data[W32-1 -: 64], o_data[63:0]);
      end else begin
        w32_t e;
        e = exp_q.pop_front();
        if (o_data !== e) begin
          errors++;
          $display("FAIL out_data: actual hi %h lo %h required hi %h lo %h",
                   o_data[W16 +: 64], o_data[63:0], e[W16 +: 64], e[63:0]);
        end
      end
      checks++;
      if (o_word_count !== 32'(exp_count)) begin
        errors++;
        $display("FAIL word_count: actual %0d required %0d", o_word_count, exp_count);
      end
      exp_count++;
    end
  end

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((src_q.size() != 0 || exp_q.size() != 0) && n < 2000) begin
      @(negedge i_clk);
      n++;
    end
    repeat (2) @(negedge i_clk);
    check(name, 64'(src_q.size() + exp_q.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    w16_t a, b, c, snap_hi;
    w32_t snap;
    int   wr_cyc[$];

    // Reset with a terminator waiting upstream: no read may happen.
    push('0);
    repeat (3) @(negedge i_clk);
    check("rst_read", 64'(o_fifo_read), 64'd0);
    check("rst_write", 64'(o_out_fifo_write), 64'd0);
    check("rst_count", 64'(o_word_count), 64'd0);
    check("rst_data", 64'(o_data[63:0] | o_data[W32-1 -: 64]), 64'd0);
    i_rst = 1'b0;
    drain("drain_init");

    // Two words A, B: write {B,A} two cycles after the first read.
    a = W16'(1);
    b = W16'(2);
    push(a);
    push(b);
    @(negedge i_clk);
    check("pair_not_early", 64'(o_out_fifo_write), 64'd0);
    @(negedge i_clk);
    check("pair_write", 64'(o_out_fifo_write), 64'd1);
    check("pair_lo", o_data[63:0], 64'd1);
    check("pair_hi", o_data[W16 +: 64], 64'd2);
    drain("drain_pair");
    check("pair_count", 64'(o_word_count), 64'd2);

    // Eight back-to-back words: four writes, spaced two cycles apart.
    for (int i = 0; i < 8; i++) push(rand_word(0));
    for (int cyc = 0; cyc < 24; cyc++) begin
      @(negedge i_clk);
      if (o_out_fifo_write === 1'b1) wr_cyc.push_back(cyc);
    end
    check("burst_writes", 64'(wr_cyc.size()), 64'd4);
    for (int i = 1; i < wr_cyc.size(); i++)
      check("burst_spacing", 64'(wr_cyc[i] - wr_cyc[i-1]), 64'd2);
    drain("drain_burst");

    // Terminator first, then A pairs with the following word.
    push(rand_word(1));
    push(rand_word(0));
    push(rand_word(0));
    drain("drain_term_first");

    // A then terminator: upper half carries the terminator word.
    push(rand_word(0));
    push('0);
    drain("drain_term_second");

    // Backpressure with output pending: reads stop and o_data holds.
    i_fifo_out_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(rand_word(0));
    repeat (3) @(negedge i_clk);
    snap = o_data;
    for (int i = 0; i < 10; i++) begin
      @(negedge i_clk);
      check("bp_read", 64'(o_fifo_read), 64'd0);
      check("bp_hold", 64'(o_data != snap), 64'd0);
    end
    i_fifo_out_ready = 1'b1;
    @(negedge i_clk);
    check("bp_resume_write", 64'(o_out_fifo_write), 64'd1);
    drain("drain_bp");

    // Randomised traffic with random downstream stalls, flushed by a terminator.
    for (int i = 0; i < 300; i++) begin
      @(negedge i_clk);
      i_fifo_out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) push(rand_word($urandom_range(0, 3) == 0));
    end
    i_fifo_out_ready = 1'b1;
    push('0);
    drain("drain_random");

    // Reset while holding A in the lower slot: A is discarded.
    a = rand_word(0);
    snap_hi = a;
    push(a);
    repeat (3) @(negedge i_clk);
    i_rst = 1'b1;
    have_lo = 0;
    exp_q.delete();
    exp_count = 0;
    @(negedge i_clk);
    check("mid_rst_count", 64'(o_word_count), 64'd0);
    check("mid_rst_write", 64'(o_out_fifo_write), 64'd0);
    i_rst = 1'b0;
    b = rand_word(0);
    c = rand_word(0);
    push(b);
    push(c);
    drain("drain_after_rst");
    check("after_rst_count", 64'(o_word_count), 64'd1);
    check("after_rst_no_a", 64'(o_data[W16-1:0] == snap_hi), 64'd0);
    check("after_rst_lo", o_data[63:0], b[63:0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
